avalon_master_sequencer: RTL

// Avalon-MM host-side sequencer: takes one command at a time from a local command

---
 rtl/avalon_master_sequencer.sv | 230 +++++++++++++++++++++++
 1 files changed

// File: rtl/avalon_master_sequencer.sv
// avalon_master_sequencer
// Host-side Avalon-MM sequencer. It takes one command at a time from a local
// command port. It then drives a single read, a single write or a burst write
// on the Avalon bus. Read data, a completion pulse, an error pulse and the last
// response code are returned to the local side.
//
// Optional feature: defining AVALON_SEQ_TIMEOUT_EN adds a 16-bit wait counter.
// The counter aborts a transfer that stalls for TIMEOUT_CYCLES cycles, and the
// transfer ends with status 11. Without the macro the sequencer waits
// indefinitely.
//
// Ports
//   i_clk, i_n_rst           clock (rising edge), asynchronous active-low reset
//   i_cmd_valid/o_cmd_ready  command handshake; ready only while idle
//   i_cmd_write/addr/len     command: direction, start word address, word count
//   i_wr_data/o_wr_pop       head of the local write FIFO and its pop strobe
//   o_rd_data/o_rd_valid     captured read data and its one-cycle valid pulse
//   o_done/o_err/o_status    completion pulse, reject/fail pulse, last response
//   o_read/o_write/...       Avalon host strobes, address, burst and write data
//   i_end_wait/...           Avalon slave handshakes, response and read data
module avalon_master_sequencer #(
    parameter logic [10:0] MAXADDR        = 11'h62C,
    parameter logic [15:0] TIMEOUT_CYCLES = 16'd1024
) (
    input  logic        i_clk,
    input  logic        i_n_rst,
    input  logic        i_cmd_valid,
    output logic        o_cmd_ready,
    input  logic        i_cmd_write,
    input  logic [10:0] i_cmd_addr,
    input  logic [9:0]  i_cmd_len,
    input  logic [31:0] i_wr_data,
    output logic        o_wr_pop,
    output logic [31:0] o_rd_data,
    output logic        o_rd_valid,
    output logic        o_done,
    output logic        o_err,
    output logic [1:0]  o_status,
    output logic        o_read,
    output logic        o_write,
    output logic        o_beginbursttransfer,
    output logic [9:0]  o_burstcount,
    output logic [10:0] o_address,
    output logic [31:0] o_writedata,
    input  logic        i_end_wait,
    input  logic        i_readdatavalid,
    input  logic        i_writeresponsevalid,
    input  logic [1:0]  i_response,
    input  logic [31:0] i_readdata
);

    typedef enum logic [2:0] {
        IDLE, RD_REQ, WR_REQ, BURST_BEGIN, BURST_DATA, DONE, ERROR
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic        r_write;
    logic [10:0] r_addr;
    logic [9:0]  r_len;
    logic [9:0]  r_cnt;
    logic [31:0] r_rd_data;
    logic [1:0]  r_status;

    logic        w_accept;
    logic        w_illegal;
    logic        w_last_word;
    logic        w_timeout;
    logic [11:0] w_end_addr;

    assign w_accept    = (r_state == IDLE) && i_cmd_valid;
    // 12-bit sum so that a range running past the top of the 11-bit space cannot wrap
    assign w_end_addr  = {1'b0, i_cmd_addr} + {2'b00, i_cmd_len};
    assign w_illegal   = (i_cmd_len == 10'd0)
                       || ((i_cmd_len > 10'd1) && !i_cmd_write)
                       || (w_end_addr > {1'b0, MAXADDR});
    assign w_last_word = (r_cnt == (r_len - 10'd1));

`ifdef AVALON_SEQ_TIMEOUT_EN
    logic [15:0] r_wait;
    logic        w_waiting;
    logic        w_progress;

    assign w_waiting  = (r_state == RD_REQ) || (r_state == WR_REQ) || (r_state == BURST_DATA);
    assign w_progress = ((r_state == RD_REQ)     && i_readdatavalid)
                     || ((r_state == WR_REQ)     && i_writeresponsevalid)
                     || ((r_state == BURST_DATA) && i_end_wait);
    // The limit is hit on the last stalled cycle, so the bus sees exactly TIMEOUT_CYCLES strobe cycles
    assign w_timeout  = w_waiting && !w_progress && (r_wait == (TIMEOUT_CYCLES - 16'd1));

    always_ff @(posedge i_clk or negedge i_n_rst) begin
        if (!i_n_rst) begin
            r_wait <= 16'd0;
        end else if (!w_waiting || w_progress) begin
            r_wait <= 16'd0;
        end else begin
            r_wait <= r_wait + 16'd1;
        end
    end
`else
    // The timeout limit has no effect when the wait counter is compiled out
    logic [15:0] w_unused_timeout;
    assign w_unused_timeout = TIMEOUT_CYCLES;
    assign w_timeout        = 1'b0;
`endif

    always_ff @(posedge i_clk or negedge i_n_rst) begin
        if (!i_n_rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (i_cmd_valid) begin
                    if (w_illegal)              w_next = ERROR;
                    else if (i_cmd_len > 10'd1) w_next = BURST_BEGIN;
                    else if (i_cmd_write)       w_next = WR_REQ;
                    else                        w_next = RD_REQ;
                end
            end
            RD_REQ: begin
                if (i_readdatavalid)   w_next = DONE;
                else if (w_timeout)    w_next = ERROR;
            end
            WR_REQ: begin
                if (i_writeresponsevalid) w_next = DONE;
                else if (w_timeout)       w_next = ERROR;
            end
            BURST_BEGIN: w_next = BURST_DATA;
            BURST_DATA: begin
                if (i_end_wait && w_last_word) w_next = DONE;
                else if (w_timeout)            w_next = ERROR;
            end
            DONE:    w_next = IDLE;
            ERROR:   w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_n_rst) begin
        if (!i_n_rst) begin
            r_write   <= 1'b0;
            r_addr    <= 11'd0;
            r_len     <= 10'd0;
            r_cnt     <= 10'd0;
            r_rd_data <= 32'd0;
            r_status  <= 2'b00;
        end else begin
            if (w_accept) begin
                r_write <= i_cmd_write;
                r_addr  <= i_cmd_addr;
                r_len   <= i_cmd_len;
                r_cnt   <= 10'd0;
                if (w_illegal) r_status <= 2'b10;
            end
            if ((r_state == RD_REQ) && i_readdatavalid) begin
                r_rd_data <= i_readdata;
                r_status  <= i_response;
            end
            if ((r_state == WR_REQ) && i_writeresponsevalid) begin
                r_status <= i_response;
            end
            if ((r_state == BURST_DATA) && i_end_wait) begin
                if (w_last_word) begin
                    r_cnt    <= 10'd0;
                    r_status <= 2'b00;
                end else begin
                    r_cnt <= r_cnt + 10'd1;
                end
            end
            if (w_timeout) r_status <= 2'b11;
        end
    end

    always_comb begin
        o_cmd_ready          = 1'b0;
        o_wr_pop             = 1'b0;
        o_rd_valid           = 1'b0;
        o_done               = 1'b0;
        o_err                = 1'b0;
        o_read               = 1'b0;
        o_write              = 1'b0;
        o_beginbursttransfer = 1'b0;
        o_burstcount         = 10'd0;
        o_address            = 11'd0;
        o_writedata          = 32'd0;
        case (r_state)
            IDLE: o_cmd_ready = 1'b1;
            RD_REQ: begin
                o_read    = 1'b1;
                o_address = r_addr;
            end
            WR_REQ: begin
                o_write     = 1'b1;
                o_address   = r_addr;
                o_writedata = i_wr_data;
                o_wr_pop    = i_writeresponsevalid;
            end
            BURST_BEGIN: begin
                o_write              = 1'b1;
                o_beginbursttransfer = 1'b1;
                o_burstcount         = r_len;
                o_address            = r_addr;
                o_writedata          = i_wr_data;
            end
            BURST_DATA: begin
                o_write      = 1'b1;
                o_burstcount = r_len;
                o_address    = r_addr + {1'b0, r_cnt};
                o_writedata  = i_wr_data;
                o_wr_pop     = i_end_wait;
            end
            DONE: begin
                o_done     = 1'b1;
                o_rd_valid = !r_write;
            end
            ERROR:   o_err = 1'b1;
            default: ;
        endcase
    end

    assign o_rd_data = r_rd_data;
    assign o_status  = r_status;

endmodule
